// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT butterfly sequencer and its compOp interface.
// Latency: none (declarations only). Backpressure: not applicable.
package fft_pkg;

    localparam logic [31:0] FP_ONE      = 32'h3F800000;
    localparam int          FP_SIGN_BIT = 31;

    localparam logic COP_ADD = 1'b0;
    localparam logic COP_MUL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MUL_ISSUE,
        MUL_WAIT,
        ADD_ISSUE,
        ADD_WAIT,
        SUB_ISSUE,
        SUB_WAIT,
        DONE
    } bfly_state_t;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    // Negation is a pure sign flip so NaN/Inf/denormal payloads are untouched.
    function automatic cplx_t cplx_neg(input cplx_t c);
        cplx_t r;
        r = c;
        r.re[FP_SIGN_BIT] = ~c.re[FP_SIGN_BIT];
        r.im[FP_SIGN_BIT] = ~c.im[FP_SIGN_BIT];
        return r;
    endfunction

endpackage

// File: rtl/fft_bfly_seq.sv
// Radix-2 DIT butterfly sequencer: T=B*W, X0=A+T, X1=A-T via three compOp issues (FFT_BFLY_TRIVIAL_TW_EN skips W=1+0j multiply).
// Latency: out_valid 4+3Lc cycles after accept (3+2Lc on the trivial-twiddle path).
// Backpressure: one job at a time; in_ready only in IDLE, results held in DONE until out_ready.
module fft_bfly_seq
    import fft_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_re,
    input  logic [W-1:0] a_im,
    input  logic [W-1:0] b_re,
    input  logic [W-1:0] b_im,
    input  logic [W-1:0] w_re,
    input  logic [W-1:0] w_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x0_re,
    output logic [W-1:0] x0_im,
    output logic [W-1:0] x1_re,
    output logic [W-1:0] x1_im,
    output logic [W-1:0] cop_re1,
    output logic [W-1:0] cop_im1,
    output logic [W-1:0] cop_re2,
    output logic [W-1:0] cop_im2,
    output logic         cop_op,
    output logic         cop_start,
    input  logic [W-1:0] cop_re,
    input  logic [W-1:0] cop_im,
    input  logic         cop_ready
);

    bfly_state_t state, state_nxt;

    cplx_t a_q, t_q, x0_q, x1_q, op1_q, op2_q;
    logic  op_q;

    cplx_t a_in, b_in, w_in, cop_res;
    logic  trivial_tw;

    assign a_in    = {a_re, a_im};
    assign b_in    = {b_re, b_im};
    assign w_in    = {w_re, w_im};
    assign cop_res = {cop_re, cop_im};

`ifdef FFT_BFLY_TRIVIAL_TW_EN
    // Bit-exact compare: -0.0 imaginary must still take the multiply path.
    assign trivial_tw = (w_re == FP_ONE) && (w_im == 32'h0);
`else
    assign trivial_tw = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (in_valid) state_nxt = trivial_tw ? ADD_ISSUE : MUL_ISSUE;
            MUL_ISSUE: state_nxt = MUL_WAIT;
            MUL_WAIT:  if (cop_ready) state_nxt = ADD_ISSUE;
            ADD_ISSUE: state_nxt = ADD_WAIT;
            ADD_WAIT:  if (cop_ready) state_nxt = SUB_ISSUE;
            SUB_ISSUE: state_nxt = SUB_WAIT;
            SUB_WAIT:  if (cop_ready) state_nxt = DONE;
            DONE:      if (out_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Operands for the next issue are loaded on the transition into it, so they
    // are already stable in the ISSUE cycle and held through the WAIT state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            t_q   <= '0;
            x0_q  <= '0;
            x1_q  <= '0;
            op1_q <= '0;
            op2_q <= '0;
            op_q  <= COP_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a_in;
                        if (trivial_tw) begin
                            t_q   <= b_in;
                            op1_q <= a_in;
                            op2_q <= b_in;
                            op_q  <= COP_ADD;
                        end else begin
                            op1_q <= b_in;
                            op2_q <= w_in;
                            op_q  <= COP_MUL;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (cop_ready) begin
                        t_q   <= cop_res;
                        op1_q <= a_q;
                        op2_q <= cop_res;
                        op_q  <= COP_ADD;
                    end
                end
                ADD_WAIT: begin
                    if (cop_ready) begin
                        x0_q  <= cop_res;
                        op2_q <= cplx_neg(t_q);
                    end
                end
                SUB_WAIT: begin
                    if (cop_ready) x1_q <= cop_res;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign cop_start = (state == MUL_ISSUE) || (state == ADD_ISSUE) || (state == SUB_ISSUE);
    assign cop_op    = op_q;

    assign cop_re1 = op1_q.re;
    assign cop_im1 = op1_q.im;
    assign cop_re2 = op2_q.re;
    assign cop_im2 = op2_q.im;

    assign x0_re = x0_q.re;
    assign x0_im = x0_q.im;
    assign x1_re = x1_q.re;
    assign x1_im = x1_q.im;

endmodule

// File: tb/tb_fft_bfly_seq.sv
// Bench for fft_bfly_seq: behavioural compOp (Lc=3), directed jobs, scoreboard-checked results.
module tb_fft_bfly_seq;

    localparam int LC = 3;
`ifdef FFT_BFLY_TRIVIAL_TW_EN
    localparam int   LAT_TRIV    = 9;
    localparam int   STARTS_TRIV = 2;
    localparam logic OP_TRIV     = 1'b0;
`else
    localparam int   LAT_TRIV    = 13;
    localparam int   STARTS_TRIV = 3;
    localparam logic OP_TRIV     = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] x0_re, x0_im, x1_re, x1_im;
    logic [31:0] cop_re1, cop_im1, cop_re2, cop_im2;
    logic        cop_op, cop_start;
    logic [31:0] cop_re, cop_im;
    logic        cop_ready;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_bfly_seq #(.W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
        .cop_re1(cop_re1), .cop_im1(cop_im1), .cop_re2(cop_re2), .cop_im2(cop_im2),
        .cop_op(cop_op), .cop_start(cop_start),
        .cop_re(cop_re), .cop_im(cop_im), .cop_ready(cop_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Single-precision <-> real for normal numbers and zeros (all vectors here).
    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        logic [10:0] e;
        if (b[30:0] == 31'h0) begin
            d = {b[31], 63'h0};
        end else begin
            e = {3'b000, b[30:23]} + 11'd896;
            d = {b[31], e, b[22:0], 29'h0};
        end
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return {d[63], 31'h0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // compOp model: zero + zero returns the second operand's zero (so 0 + -0 = -0).
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        if (x[30:0] == 31'h0 && y[30:0] == 31'h0) return y;
        return r2f(f2r(x) + f2r(y));
    endfunction

    logic [31:0] m_re, m_im;
    logic        m_rdy;
    logic        spur = 1'b0;
    int          m_cnt;

    assign cop_ready = m_rdy | spur;
    assign cop_re    = spur ? 32'hDEADBEEF : m_re;
    assign cop_im    = spur ? 32'hBADC0FFE : m_im;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rdy <= 1'b0;
            m_cnt <= 0;
            m_re  <= '0;
            m_im  <= '0;
        end else begin
            m_rdy <= 1'b0;
            if (cop_start) begin
                if (cop_op) begin
                    m_re <= r2f(f2r(cop_re1) * f2r(cop_re2) - f2r(cop_im1) * f2r(cop_im2));
                    m_im <= r2f(f2r(cop_re1) * f2r(cop_im2) + f2r(cop_im1) * f2r(cop_re2));
                end else begin
                    m_re <= fadd(cop_re1, cop_re2);
                    m_im <= fadd(cop_im1, cop_im2);
                end
                if (LC == 1) m_rdy <= 1'b1;
                else m_cnt <= LC - 1;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_rdy <= 1'b1;
            end
        end
    end

    typedef struct {
        logic [31:0] x0re, x0im, x1re, x1im;
        int          lat;
        int          starts;
        logic        op1;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input logic [31:0] x0r, x0i, x1r, x1i,
                                input int lat, input int st, input logic op);
        exp_t e;
        e.x0re = x0r; e.x0im = x0i; e.x1re = x1r; e.x1im = x1i;
        e.lat = lat; e.starts = st; e.op1 = op;
        return e;
    endfunction

    int   acc_cyc  = 0;
    int   n_starts = 0;
    int   out_lat  = 0;
    logic first_op = 1'b0;
    bit   seen_out = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            n_starts = 0;
            seen_out = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                acc_cyc  = cyc;
                n_starts = 0;
                seen_out = 1'b0;
            end
            if (cop_start) begin
                if (n_starts == 0) first_op = cop_op;
                n_starts++;
            end
            if (out_valid && !seen_out) begin
                seen_out = 1'b1;
                out_lat  = cyc - acc_cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $display("FAIL unexpected_output: got x0_re %h, expected no result", x0_re);
                end else begin
                    e = sb.pop_front();
                    chk("x0_re", x0_re, e.x0re);
                    chk("x0_im", x0_im, e.x0im);
                    chk("x1_re", x1_re, e.x1re);
                    chk("x1_im", x1_im, e.x1im);
                    chk("latency", out_lat, e.lat);
                    chk("cop_start_count", n_starts, e.starts);
                    chk("first_cop_op", {31'h0, first_op}, {31'h0, e.op1});
                end
                seen_out = 1'b0;
            end
        end
    end

    task automatic send_job(input logic [31:0] ar, ai, br, bi, wr, wi,
                            input exp_t e, input bit push, input bit spur_mul);
        int t;
        t = 0;
        while (!in_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            ncmp++;
            nerr++;
            $display("FAIL in_ready_timeout: got 0, expected 1 within 500 cycles");
            return;
        end
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        in_valid = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (spur_mul) begin
            spur = 1'b1;
            @(posedge clk); #1;
            spur = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int cnt;

        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_cop_start", {31'h0, cop_start}, 32'h0);
        chk("rst_cop_op", {31'h0, cop_op}, 32'h0);
        chk("rst_x0_re", x0_re, 32'h0);
        chk("rst_x1_im", x1_im, 32'h0);
        chk("rst_cop_re1", cop_re1, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Stray cop_ready while idle must not move the FSM.
        @(posedge clk); #1;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        chk("idle_spur_in_ready", {31'h0, in_ready}, 32'h1);
        chk("idle_spur_cop_start", {31'h0, cop_start}, 32'h0);

        // Trivial twiddle 1+0j, with a stray cop_ready in the first cycle after accept.
        send_job(32'h41A80000, 32'h42400000, 32'h42920000, 32'hC1400000, 32'h3F800000, 32'h00000000,
                 mk(32'h42BC0000, 32'h42100000, 32'hC2500000, 32'h42700000, LAT_TRIV, STARTS_TRIV, OP_TRIV),
                 1'b1, 1'b1);

        // 1 - 0j is not bit-identical to 1+0j: always the full path.
        send_job(32'h41A80000, 32'h42400000, 32'h42920000, 32'hC1400000, 32'h3F800000, 32'h80000000,
                 mk(32'h42BC0000, 32'h42100000, 32'hC2500000, 32'h42700000, 13, 3, 1'b1),
                 1'b1, 1'b0);

        // W = j, A = 0, B = 1: X1 real is -0.0.
        send_job(32'h00000000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000,
                 mk(32'h00000000, 32'h3F800000, 32'h80000000, 32'hBF800000, 13, 3, 1'b1),
                 1'b1, 1'b0);

        // Stall in DONE for 10 cycles.
        t = 0;
        while (!in_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b0;
        send_job(32'h41A80000, 32'h42400000, 32'h42920000, 32'hC1400000, 32'h3F800000, 32'h00000000,
                 mk(32'h42BC0000, 32'h42100000, 32'hC2500000, 32'h42700000, LAT_TRIV, STARTS_TRIV, OP_TRIV),
                 1'b1, 1'b0);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("stall_reached_done", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            chk("stall_cop_start", {31'h0, cop_start}, 32'h0);
            chk("stall_x0_re", x0_re, 32'h42BC0000);
            chk("stall_x1_re", x1_re, 32'hC2500000);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Reset during ADD_WAIT (full-path job so ADD_WAIT follows the second issue).
        send_job(32'h41A80000, 32'h42400000, 32'h42920000, 32'hC1400000, 32'h3F800000, 32'h80000000,
                 mk(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0), 1'b0, 1'b0);
        cnt = 1;
        t = 0;
        while (cnt < 2 && t < 500) begin
            @(negedge clk);
            if (cop_start) cnt++;
            t++;
        end
        chk("second_issue_seen", cnt, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_cop_start", {31'h0, cop_start}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("midrst_cop_re1", cop_re1, 32'h0);
        chk("midrst_cop_op", {31'h0, cop_op}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_release_in_ready", {31'h0, in_ready}, 32'h1);

        send_job(32'h00000000, 32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000,
                 mk(32'h00000000, 32'h3F800000, 32'h80000000, 32'hBF800000, 13, 3, 1'b1),
                 1'b1, 1'b0);

        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        ncmp++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/fft_bfly_seq.md
# fft_bfly_seq

Radix-2 decimation-in-time butterfly sequencer for the FFT datapath. It accepts one butterfly job: samples A and B and twiddle W, each as single-precision IEEE-754 complex pairs. It drives the shared `compOp` complex arithmetic unit three times, computing T = B·W, X0 = A + T and X1 = A − T, and presents X0/X1 to the write-back stage. It sits directly upstream of `compOp`, issuing operands and op codes, and directly downstream of it, consuming its results.

## Interface
Parameters:
- `W`, 32, float word width (fixed IEEE-754 single; not to be changed).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  job offered.
- `in_ready`  out  1  block can accept a job (high only in IDLE).
- `a_re`, `a_im`, `b_re`, `b_im`, `w_re`, `w_im`  in  32 each  job operands.
- `out_valid`  out  1  X0/X1 held valid.
- `out_ready`  in  1  consumer accepts the result.
- `x0_re`, `x0_im`, `x1_re`, `x1_im`  out  32 each  butterfly results.
- `cop_re1`, `cop_im1`, `cop_re2`, `cop_im2`  out  32 each  operands to `compOp`.
- `cop_op`  out  1  0 = complex add, 1 = complex multiply.
- `cop_start`  out  1  one-cycle issue pulse to `compOp`.
- `cop_re`, `cop_im`  in  32 each  `compOp` result.
- `cop_ready`  in  1  `compOp` result valid this cycle.

## Operation
- States are IDLE, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, SUB_ISSUE, SUB_WAIT, DONE.
- **IDLE:** `in_ready` = 1. On `in_valid` the block registers A, B and W and moves to MUL_ISSUE.
- **MUL_ISSUE:** drives `cop_start` = 1, `cop_op` = 1, operands B, W, then moves to MUL_WAIT.
- **MUL_WAIT:** on `cop_ready` the block latches T and moves to ADD_ISSUE.
- **ADD_ISSUE:** issues A + T with `cop_op` = 0, then moves to ADD_WAIT.
- **ADD_WAIT:** on `cop_ready` the block latches X0 and moves to SUB_ISSUE.
- **SUB_ISSUE:** issues A + (−T) with `cop_op` = 0. −T is formed by inverting bit 31 of both `t_re` and `t_im`; no other arithmetic is done locally. Then the block moves to SUB_WAIT.
- **SUB_WAIT:** on `cop_ready` the block latches X1 and moves to DONE.
- **DONE:** `out_valid` = 1 with X0/X1 stable. On `out_ready` it returns to IDLE.
- `cop_*` operand and op outputs are registered and held stable from each ISSUE cycle until the matching `cop_ready`.
- `cop_ready` is ignored in every state except the three WAIT states, including IDLE and ISSUE cycles.
- Special values (NaN, Inf, denormals) pass through unmodified; the sign flip applies to them too.

## Timing
- Reset values: `in_ready` = 0 during reset and 1 on the first cycle after reset, in IDLE. `out_valid`, `cop_start` and `cop_op` = 0. All data outputs = 32'h0. State = IDLE.
- `compOp` latency Lc ≥ 1 cycles is measured from the `cop_start` cycle to the `cop_ready` cycle.
- Job accepted in cycle 0: `cop_start` pulses in cycles 1, 2+Lc and 3+2Lc, and `out_valid` rises in cycle 4+3Lc.
- Back-to-back jobs: the next `in_ready` comes one cycle after the `out_ready` handshake. There is no overlap of jobs.
- `out_valid` held with `out_ready` = 0: the block stalls indefinitely in DONE with outputs stable.
- `rst` asserted mid-job: the job is abandoned, outputs return to reset values, and `cop_start` drops immediately. `compOp` shares `rst`, so no stale `cop_ready` is expected. Any stale `cop_ready` that does arrive is ignored in IDLE.

## Configuration
- `FFT_BFLY_TRIVIAL_TW_EN` defined:
  - If W = 32'h3F800000 + j32'h00000000 (exactly 1 + 0j), the block sets T = B, skips MUL_ISSUE and MUL_WAIT, and goes from IDLE directly to ADD_ISSUE.
  - Latency becomes 3+2Lc.
  - Any other W, including −0.0 imaginary, takes the full path.
- Not defined: every job issues the multiply and there is no W comparator.

## Structure
- Shared package `fft_pkg` holds:
  - `FP_ONE` = 32'h3F800000 and `FP_SIGN_BIT` = 31.
  - `COP_ADD` = 1'b0 and `COP_MUL` = 1'b1.
  - The `bfly_state_t` enum.
  - A `cplx_t` struct {re, im}.
- No sub-module. `compOp` is instantiated beside this block at the next level up, not inside it.

## Test plan
Bench uses a `compOp` behavioural model with Lc = 3 unless stated.
- Trivial twiddle, macro defined: A = (41A80000, 42400000) (21+48j), B = (42920000, C1400000) (73−12j), W = 1+0j -> X0 = (42BC0000, 42100000) (94+36j), X1 = (C2500000, 42700000) (−52+60j), `out_valid` in cycle 9, exactly two `cop_start` pulses.
- Same job, macro undefined -> same X0/X1, three `cop_start` pulses with the first at `cop_op` = 1, `out_valid` in cycle 13.
- W = 0+1j (00000000, 3F800000), A = 0, B = 1+0j -> T = 0+1j, X0 = (00000000, 3F800000), X1 = (80000000, BF800000); the X1 real part is −0.0, as produced by `compOp` for 0 + (−0).
- Hold `out_ready` = 0 for 10 cycles in DONE -> `out_valid` stays 1, outputs stable, `in_ready` stays 0, no `cop_start` pulses.
- Assert `rst` in ADD_WAIT -> the same cycle shows `out_valid` = 0 and `cop_start` = 0. After release, a new job completes with correct results.
- Spurious `cop_ready` pulses injected in IDLE and in MUL_ISSUE -> no state change, no result corruption.
